i2c_simple_slave: RTL and testbench

I2C_SIMPLE_SLAVE -- requirements
Module: i2c_simple_slave

---
 rtl/i2c_simple_pkg.sv | 14 +
 rtl/i2c_line_filter.sv | 55 +++++
 rtl/i2c_simple_slave.sv | 150 +++++++++++++++
 tb/tb_i2c_simple_slave.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_simple_pkg.sv
// Shared types and sizing for the simple I2C receive-only slave.
package i2c_simple_pkg;

    localparam int MAX_BYTES = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ACK,
        WAIT_REL
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer for one bus line, with an optional run-length glitch filter
// enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Idle bus level is high, so the chain resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= line_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] run_q;
    logic          level_q;

    // A new level is accepted only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= '0;
            level_q <= 1'b1;
        end else if (sync_q[SYNC_STAGES-1] == level_q) begin
            run_q <= '0;
        end else if (run_q == CW'(FILTER_LEN - 1)) begin
            level_q <= sync_q[SYNC_STAGES-1];
            run_q   <= '0;
        end else begin
            run_q <= run_q + CW'(1);
        end
    end

    assign line_o = level_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN > 0);
    assign line_o            = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/i2c_simple_slave.sv
// Receive-only I2C slave: captures up to MAX_BYTES per frame and ACKs each.
// Optional line glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_simple_slave
    import i2c_simple_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scl_in,
    input  logic                          sda_in,
    output logic                          sda_out,
    output logic                          sda_out_en,
    output logic [MAX_BYTES-1:0][7:0]     data_array,
    output logic [CNT_W-1:0]              byte_count,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          overflow
);

    logic scl_s, sda_s, scl_d_q, sda_d_q;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst_n(rst_n), .line_i(scl_in), .line_o(scl_s)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst_n(rst_n), .line_i(sda_in), .line_o(sda_s)
    );

    logic start, stop, scl_rise, scl_fall;

    assign start    = scl_s & scl_d_q & sda_d_q & ~sda_s;
    assign stop     = scl_s & scl_d_q & ~sda_d_q & sda_s;
    assign scl_rise = scl_s & ~scl_d_q;
    assign scl_fall = ~scl_s & scl_d_q;

    state_t                      state_q, state_d;
    logic [7:0]                  shift_q, shift_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [MAX_BYTES-1:0][7:0]   bytes_q, bytes_d;
    logic                        ovf_q, ovf_d;
    logic                        sda_en_q, sda_en_d;
    logic [MAX_BYTES-1:0][7:0]   data_q, data_d;
    logic [CNT_W-1:0]            bcnt_q, bcnt_d;
    logic                        ovfo_q, ovfo_d;
    logic                        done_q, done_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        bytes_d   = bytes_q;
        ovf_d     = ovf_q;
        sda_en_d  = sda_en_q;
        data_d    = data_q;
        bcnt_d    = bcnt_q;
        ovfo_d    = ovfo_q;
        done_d    = 1'b0;
        if (start) begin
            state_d   = RECV;
            cnt_d     = '0;
            bit_cnt_d = '0;
            ovf_d     = 1'b0;
            sda_en_d  = 1'b0;
        end else if (stop && state_q != IDLE) begin
            // Any partial byte in shift_q is simply dropped here.
            state_d  = IDLE;
            sda_en_d = 1'b0;
            data_d   = bytes_q;
            bcnt_d   = cnt_q;
            ovfo_d   = ovf_q;
            done_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                RECV: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {sda_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = ACK;
                        if (cnt_q < CNT_W'(MAX_BYTES)) begin
                            bytes_d[cnt_q[2:0]] = shift_q;
                            cnt_d               = cnt_q + CNT_W'(1);
                            sda_en_d            = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (scl_rise) state_d = WAIT_REL;
                end
                WAIT_REL: begin
                    if (scl_fall) begin
                        state_d   = RECV;
                        sda_en_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            bytes_q   <= '0;
            ovf_q     <= 1'b0;
            sda_en_q  <= 1'b0;
            data_q    <= '0;
            bcnt_q    <= '0;
            ovfo_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_d_q   <= 1'b1;
            sda_d_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            bytes_q   <= bytes_d;
            ovf_q     <= ovf_d;
            sda_en_q  <= sda_en_d;
            data_q    <= data_d;
            bcnt_q    <= bcnt_d;
            ovfo_q    <= ovfo_d;
            done_q    <= done_d;
            scl_d_q   <= scl_s;
            sda_d_q   <= sda_s;
        end
    end

    assign sda_out    = 1'b0;
    assign sda_out_en = sda_en_q;
    assign data_array = data_q;
    assign byte_count = bcnt_q;
    assign overflow   = ovfo_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_simple_slave.sv
// Directed and randomized I2C master frames against a byte-queue frame model.
module tb_i2c_simple_slave;

    localparam int Q = 25;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            scl_in;
    logic            sda_in;
    logic            sda_out;
    logic            sda_out_en;
    logic [7:0][7:0] data_array;
    logic [3:0]      byte_count;
    logic            frame_done;
    logic            busy;
    logic            overflow;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    bit busy_seen;

    logic [7:0] model_q[$];
    logic [7:0] stim[16];

    i2c_simple_slave #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_out(sda_out), .sda_out_en(sda_out_en),
        .data_array(data_array), .byte_count(byte_count),
        .frame_done(frame_done), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_in = 1'b1; tick(Q);
        scl_in = 1'b1; tick(Q);
        sda_in = 1'b0; tick(Q);
        scl_in = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_in = 1'b0; tick(Q);
        scl_in = 1'b1; tick(Q);
        sda_in = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_in = b[i]; tick(Q);
            scl_in = 1'b1; tick(2 * Q);
            scl_in = 1'b0; tick(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        logic exp_ack;
        exp_ack = (model_q.size() < 8);
        send_bits(b, 8);
        sda_in = 1'b1; tick(Q);
        scl_in = 1'b1; tick(Q);
        chk("ack_en", {63'd0, sda_out_en}, {63'd0, exp_ack});
        tick(Q);
        scl_in = 1'b0; tick(Q);
        model_q.push_back(b);
    endtask

    task automatic run_frame(input int n, input int rs_at,
                             input int pbits, input logic [7:0] pdata);
        int fd_base;
        int nexp;
        fd_base = fd_cnt;
        i2c_start();
        model_q.delete();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 0; i < n; i++) begin
            if (i == rs_at) begin
                i2c_start();
                model_q.delete();
            end
            write_byte(stim[i]);
        end
        if (pbits > 0) send_bits(pdata, pbits);
        i2c_stop();
        nexp = (model_q.size() > 8) ? 8 : model_q.size();
        chk("frame_done_count", 64'(fd_cnt - fd_base), 64'd1);
        chk("busy_after_stop", {63'd0, busy}, 64'd0);
        chk("byte_count", {60'd0, byte_count}, 64'(nexp));
        chk("overflow", {63'd0, overflow}, {63'd0, model_q.size() > 8});
        for (int i = 0; i < nexp; i++) begin
            chk("data_array", {56'd0, data_array[i]}, {56'd0, model_q[i]});
        end
    endtask

    initial begin
        int n, rs, pb;
        rst_n  = 1'b0;
        scl_in = 1'b1;
        sda_in = 1'b1;
        tick(5);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_sda_en", {63'd0, sda_out_en}, 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        chk("rst_byte_count", {60'd0, byte_count}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_data", data_array, 64'd0);
        chk("sda_out_const", {63'd0, sda_out}, 64'd0);
        rst_n = 1'b1;
        tick(5);

        stim[0] = 8'hA5; stim[1] = 8'h3C;
        run_frame(2, -1, 0, 8'h00);

        for (int i = 0; i < 9; i++) stim[i] = 8'(i);
        run_frame(9, -1, 0, 8'h00);

        stim[0] = 8'h81;
        run_frame(1, -1, 5, 8'h1F);

        stim[0] = 8'h11; stim[1] = 8'h22;
        run_frame(2, 1, 0, 8'h00);

        busy_seen = 1'b0;
        tick(5);
        sda_in = 1'b0; tick(2);
        sda_in = 1'b1; tick(20);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        chk("glitch_busy", {63'd0, busy_seen}, 64'd0);
`else
        chk("glitch_busy", {63'd0, busy_seen}, 64'd1);
`endif
        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; tick(5);

        i2c_start();
        send_bits(8'hC3, 8);
        sda_in = 1'b1; tick(Q);
        scl_in = 1'b1; tick(Q);
        chk("pre_reset_ack", {63'd0, sda_out_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_release_sda", {63'd0, sda_out_en}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_data", data_array, 64'd0);
        chk("reset_byte_count", {60'd0, byte_count}, 64'd0);
        chk("reset_overflow", {63'd0, overflow}, 64'd0);
        chk("reset_frame_done", {63'd0, frame_done}, 64'd0);
        tick(3);
        scl_in = 1'b1;
        sda_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);

        for (int f = 0; f < 4; f++) begin
            n  = int'($urandom_range(0, 9));
            rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            pb = int'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
            run_frame(n, rs, pb, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
